// File: rtl/mamba_mem_pkg.sv
// Shared memory-side definitions for the Mamba datapath: BRAM geometry and
// the read-sequencer state encoding.
package mamba_mem_pkg;

    localparam int BRAM_ADDR_WIDTH   = 15;
    localparam int BRAM_DATA_WIDTH   = 256;
    localparam int READER_LEN_WIDTH  = 16;
    localparam int READER_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready beat stream carrying one BRAM word plus an end-of-burst tag.
interface bram_stream_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stream_fifo.sv
// Small first-word-fall-through FIFO with occupancy count and synchronous flush.
module stream_fifo
    import mamba_mem_pkg::*;
#(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          not_empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !flush;
    assign do_pop    = pop && (count_reg != '0) && !flush;
    assign not_empty = (count_reg != '0);
    assign count     = count_reg;
    // Output reads as zero while empty so nothing stale shows on the bus.
    assign pop_data  = not_empty ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous BRAM address range on the registered read port and
// re-times the returned words into a backpressured valid/ready stream.
module bram_stream_reader
    import mamba_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
    parameter int LEN_WIDTH  = READER_LEN_WIDTH,
    parameter int FIFO_DEPTH = READER_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    bram_stream_if.master         m,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = count_width(FIFO_DEPTH);

    reader_state_t         state_reg;
    reader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] next_addr_reg;
    logic [LEN_WIDTH-1:0]  remaining_reg;
    logic                  v0_reg;
    logic                  v1_reg;
    logic                  last0_reg;
    logic                  last1_reg;

    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  fifo_not_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  accept_start;
    logic                  kill;
    logic                  issue;
    logic                  handshake;

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign kill         = abort && busy;
    assign accept_start = (state_reg == IDLE) && start && !abort;

    // Reads in the RAM pipeline count against FIFO space so a push never overflows.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(v0_reg) + (CW+1)'(v1_reg);
    assign issue     = (state_reg == RUN) && (remaining_reg != '0) && !abort
                       && (occupancy < (CW+1)'(FIFO_DEPTH));

    assign handshake = fifo_not_empty && m.ready;
    assign m.valid   = fifo_not_empty;
    assign m.last    = fifo_head[DATA_WIDTH];
    assign m.data    = fifo_head[DATA_WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_start) begin
                    state_next = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining_reg == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && m.last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bram_addr     <= '0;
            next_addr_reg <= '0;
            remaining_reg <= '0;
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            last0_reg     <= 1'b0;
            last1_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            v1_reg    <= v0_reg && !kill;
            last1_reg <= last0_reg;
            if (kill) begin
                v0_reg <= 1'b0;
            end else if (accept_start && (burst_len != '0)) begin
                // First read goes out on the accepting edge to hit the 2-cycle latency.
                bram_addr     <= base_addr;
                next_addr_reg <= base_addr + ADDR_WIDTH'(1);
                remaining_reg <= burst_len - LEN_WIDTH'(1);
                v0_reg        <= 1'b1;
                last0_reg     <= (burst_len == LEN_WIDTH'(1));
            end else if (issue) begin
                bram_addr     <= next_addr_reg;
                next_addr_reg <= next_addr_reg + ADDR_WIDTH'(1);
                remaining_reg <= remaining_reg - LEN_WIDTH'(1);
                v0_reg        <= 1'b1;
                last0_reg     <= (remaining_reg == LEN_WIDTH'(1));
            end else begin
                v0_reg <= 1'b0;
            end
        end
    end

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (kill),
        .push      (v1_reg),
        .push_data ({last1_reg, bram_dout}),
        .pop       (handshake),
        .pop_data  (fifo_head),
        .not_empty (fifo_not_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench: table of bursts plus abort, start/abort collision and mid-burst reset sequences.
module tb_bram_stream_reader;
    import mamba_mem_pkg::*;

    localparam int AW    = 15;
    localparam int DW    = 256;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic          busy;
    logic          done;

    bram_stream_if #(.DATA_WIDTH(DW)) m_if ();

    int checks = 0;
    int errors = 0;
    int max_fifo = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            mode;      // 0: ready held high, 1: ready pattern 1,0,0,1
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_final;
        int            exp_beats;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // RAM model: registered read, word k holds value k.
    always @(posedge clk) bram_dout <= DW'(bram_addr);

    always @(negedge clk) begin
        if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
    end

    bram_stream_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .abort     (abort),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m         (m_if),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        logic [AW-1:0] addr_before;
        logic [DW-1:0] held;
        logic [AW-1:0] first_seen;
        logic [AW-1:0] final_seen;
        int            beats;
        bit            stalled;
        bit            got_last;
        addr_before = bram_addr;
        first_seen  = '1;
        final_seen  = '1;
        held        = '0;
        beats       = 0;
        stalled     = 1'b0;
        got_last    = 1'b0;
        start     = 1'b1;
        base_addr = v.base;
        burst_len = v.len;
        m_if.ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        if (v.len == '0) begin
            check("len0_addr", bram_addr, addr_before);
            check("len0_valid", m_if.valid, 1'b0);
            check("len0_done", done, 1'b1);
            @(negedge clk);
            check("len0_done_clear", done, 1'b0);
            check("len0_busy_clear", busy, 1'b0);
            check("len0_valid_after", m_if.valid, 1'b0);
            $display("burst base=%0h len=%0d mode=%0d beats=0", v.base, v.len, v.mode);
            return;
        end
        check("addr_latency", bram_addr, v.base);
        check("valid_n", m_if.valid, 1'b0);
        @(negedge clk);
        check("valid_n1", m_if.valid, 1'b0);
        @(negedge clk);
        check("valid_n2", m_if.valid, 1'b1);
        for (int cyc = 0; cyc < 400 && !got_last; cyc++) begin
            if (cyc > 0) @(negedge clk);
            m_if.ready = (v.mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                check("stall_valid", m_if.valid, 1'b1);
                check("stall_data", m_if.data, held);
            end
            if (v.mode == 0) check("no_bubble", m_if.valid, 1'b1);
            if (m_if.valid && m_if.ready) begin
                check("beat_data", m_if.data, DW'(AW'(v.base + AW'(beats))));
                check("beat_last", m_if.last, (beats == int'(v.len) - 1));
                if (beats == 0) first_seen = m_if.data[AW-1:0];
                final_seen = m_if.data[AW-1:0];
                got_last   = m_if.last;
                beats++;
            end
            stalled = m_if.valid && !m_if.ready;
            held    = m_if.data;
        end
        if (!got_last) check("burst_timeout", 1'b0, 1'b1);
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("valid_after_last", m_if.valid, 1'b0);
        @(negedge clk);
        check("done_clear", done, 1'b0);
        check("busy_clear", busy, 1'b0);
        check("beat_count", beats, v.exp_beats);
        check("first_beat", first_seen, v.exp_first);
        check("final_beat", final_seen, v.exp_final);
        $display("burst base=%0h len=%0d mode=%0d beats=%0d first=%0h final=%0h",
                 v.base, v.len, v.mode, beats, first_seen, final_seen);
    endtask

    initial begin
        logic [AW-1:0] addr_hold;
        int hs;

        vecs[0] = '{15'h0000, 16'd8, 0, 15'h0000, 15'h0007, 8};
        vecs[1] = '{15'h0000, 16'd8, 1, 15'h0000, 15'h0007, 8};
        vecs[2] = '{15'h7FFE, 16'd4, 0, 15'h7FFE, 15'h0001, 4};
        vecs[3] = '{15'h0123, 16'd0, 0, 15'h0000, 15'h0000, 0};
        vecs[4] = '{15'h0005, 16'd1, 1, 15'h0005, 15'h0005, 1};
        vecs[5] = '{15'h0100, 16'd2, 0, 15'h0100, 15'h0101, 2};

        m_if.ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", m_if.valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_addr", bram_addr, '0);
        check("reset_data", m_if.data, '0);
        check("reset_last", m_if.last, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
        end

        // Abort after the third handshake of a 16-beat burst.
        start = 1'b1; base_addr = 15'h0000; burst_len = 16'd16; m_if.ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            if (m_if.valid && m_if.ready) hs++;
        end
        @(negedge clk);
        check("abort_hs_count", hs, 3);
        abort = 1'b1;
        m_if.ready = 1'b0;
        addr_hold = bram_addr;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", m_if.valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_addr_hold", bram_addr, addr_hold);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_stale", m_if.valid, 1'b0);
            check("abort_no_done", done, 1'b0);
        end
        $display("abort after %0d beats, addr held at %0h", hs, addr_hold);
        run_burst(vecs[5]);

        // start and abort together in IDLE: abort wins, nothing launches.
        addr_hold = bram_addr;
        start = 1'b1; abort = 1'b1; base_addr = 15'h0055; burst_len = 16'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("collide_busy", busy, 1'b0);
        check("collide_addr", bram_addr, addr_hold);
        @(negedge clk);
        check("collide_valid", m_if.valid, 1'b0);
        $display("start+abort in idle ignored");

        // Reset mid-burst with the FIFO full and the consumer stalled.
        start = 1'b1; base_addr = 15'h0000; burst_len = 16'd16; m_if.ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("full_count", dut.fifo_count, DEPTH);
        check("full_valid", m_if.valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", m_if.valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_addr", bram_addr, '0);
        check("midrst_data", m_if.data, '0);
        check("midrst_last", m_if.last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("postrst_valid", m_if.valid, 1'b0);
            check("postrst_busy", busy, 1'b0);
        end
        $display("mid-burst reset released");
        run_burst(vecs[0]);

        check("fifo_max", (max_fifo <= DEPTH), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
